ulpi_reg_port: RTL

- ULPI link-side register access engine, clocked by the PHY's 60 MHz CLKOUT.
- Sits between the PHY pins and the bring-up sequencer, which issues register read/write requests. Read results go downstream to the UART transmitter path.
- Implements TXCMD, data phase, STP, turnaround and abort per ULPI 1.1.
- Also captures RX CMD bytes the PHY sends while the block is idle.

---
 rtl/ulpi_reg_port.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/ulpi_reg_port.sv
// ULPI link-side register access engine: issues TXCMD register reads/writes,
// handles PHY abort with automatic retry, and captures RX CMD bytes while idle.
module ulpi_reg_port #(
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic       CLKOUT,
    input  logic       reset,
    input  logic       DIR,
    input  logic       NXT,
    output logic       STP,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    input  logic       req,
    input  logic       req_we,
    input  logic [5:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] rdata,
    output logic       aborted,
    output logic       rxcmd_valid,
    output logic [7:0] rxcmd
);

    typedef enum logic [3:0] {
        IDLE, TXCMD, WDATA, WSTP, RTURN, RDATA, RX, RXEND, FAIL
    } state_t;

    state_t        state_reg, state_next;
    logic          dir_q_reg;
    logic [TW-1:0] cnt_reg, cnt_next;
    logic          retry_reg, retry_next;
    logic          we_reg, we_next;
    logic [5:0]    addr_reg, addr_next;
    logic [7:0]    wdata_reg, wdata_next;
    logic          stp_reg, stp_next;
    logic [7:0]    data_out_reg, data_out_next;
    logic          drive_en_reg, drive_en_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic          err_reg, err_next;
    logic          aborted_reg, aborted_next;
    logic          rxcmd_valid_reg, rxcmd_valid_next;
    logic [7:0]    rdata_reg, rdata_next;
    logic [7:0]    rxcmd_reg, rxcmd_next;

    logic timeout;
    assign timeout = (cnt_reg == TW'(TIMEOUT));

    // State register
    always_ff @(posedge CLKOUT or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; DIR wins over NXT and req in every driving state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (DIR)                     state_next = RX;
                else if (req || retry_reg)   state_next = TXCMD;
            end
            TXCMD: begin
                if (DIR)                     state_next = RX;
                else if (NXT)                state_next = we_reg ? WDATA : RTURN;
                else if (timeout)            state_next = FAIL;
            end
            WDATA: begin
                if (DIR)                     state_next = RX;
                else if (NXT)                state_next = WSTP;
                else if (timeout)            state_next = FAIL;
            end
            WSTP:                            state_next = IDLE;
            RTURN: begin
                if (DIR)                     state_next = NXT ? RX : RDATA;
                else if (timeout)            state_next = FAIL;
            end
            RDATA:                           state_next = DIR ? RX : FAIL;
            RX: begin
                if (!DIR)                    state_next = RXEND;
            end
            RXEND:                           state_next = IDLE;
            FAIL:                            state_next = IDLE;
            default:                         state_next = IDLE;
        endcase
    end

    // Output logic: every registered output is computed for the state being entered
    always_comb begin
        cnt_next         = cnt_reg;
        retry_next       = retry_reg;
        we_next          = we_reg;
        addr_next        = addr_reg;
        wdata_next       = wdata_reg;
        busy_next        = busy_reg;
        done_next        = 1'b0;
        err_next         = 1'b0;
        aborted_next     = 1'b0;
        rxcmd_valid_next = 1'b0;
        rdata_next       = rdata_reg;
        rxcmd_next       = rxcmd_reg;
        stp_next         = 1'b0;
        data_out_next    = 8'h00;
        drive_en_next    = 1'b1;

        case (state_reg)
            IDLE: begin
                if (state_next == TXCMD) begin
                    // A retry replays the request latched before the abort
                    if (!retry_reg) begin
                        we_next    = req_we;
                        addr_next  = req_addr;
                        wdata_next = req_wdata;
                    end
                    busy_next = 1'b1;
                    cnt_next  = '0;
                end
            end
            TXCMD, WDATA, RTURN: begin
                if (state_next == RX) begin
                    aborted_next = 1'b1;
                    retry_next   = 1'b1;
                end else if (state_next == state_reg) begin
                    cnt_next = cnt_reg + TW'(1);
                end
            end
            RDATA: begin
                if (DIR) begin
                    rdata_next = data_in;
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    retry_next = 1'b0;
                end
            end
            RX: begin
                // Turnaround cycles and NXT-qualified USB data are not RX CMDs
                if (DIR && dir_q_reg && !NXT) begin
                    rxcmd_next       = data_in;
                    rxcmd_valid_next = 1'b1;
                end
            end
            default: ;
        endcase

        case (state_next)
            TXCMD:       data_out_next = {(we_next ? 2'b10 : 2'b11), addr_next};
            WDATA:       data_out_next = wdata_next;
            WSTP: begin
                stp_next   = 1'b1;
                done_next  = 1'b1;
                busy_next  = 1'b0;
                retry_next = 1'b0;
            end
            FAIL: begin
                stp_next   = 1'b1;
                done_next  = 1'b1;
                err_next   = 1'b1;
                busy_next  = 1'b0;
                retry_next = 1'b0;
            end
            RTURN, RDATA, RX: drive_en_next = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge CLKOUT or negedge reset) begin
        if (!reset) begin
            dir_q_reg       <= 1'b0;
            cnt_reg         <= '0;
            retry_reg       <= 1'b0;
            we_reg          <= 1'b0;
            addr_reg        <= 6'h00;
            wdata_reg       <= 8'h00;
            stp_reg         <= 1'b0;
            data_out_reg    <= 8'h00;
            drive_en_reg    <= 1'b1;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            err_reg         <= 1'b0;
            aborted_reg     <= 1'b0;
            rxcmd_valid_reg <= 1'b0;
            rdata_reg       <= 8'h00;
            rxcmd_reg       <= 8'h00;
        end else begin
            dir_q_reg       <= DIR;
            cnt_reg         <= cnt_next;
            retry_reg       <= retry_next;
            we_reg          <= we_next;
            addr_reg        <= addr_next;
            wdata_reg       <= wdata_next;
            stp_reg         <= stp_next;
            data_out_reg    <= data_out_next;
            drive_en_reg    <= drive_en_next;
            busy_reg        <= busy_next;
            done_reg        <= done_next;
            err_reg         <= err_next;
            aborted_reg     <= aborted_next;
            rxcmd_valid_reg <= rxcmd_valid_next;
            rdata_reg       <= rdata_next;
            rxcmd_reg       <= rxcmd_next;
        end
    end

    // Bus is released combinationally the cycle DIR rises
    assign data_oe     = ~DIR & drive_en_reg;
    assign STP         = stp_reg;
    assign data_out    = data_out_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign err         = err_reg;
    assign rdata       = rdata_reg;
    assign aborted     = aborted_reg;
    assign rxcmd_valid = rxcmd_valid_reg;
    assign rxcmd       = rxcmd_reg;

endmodule
